// File: rtl/ga_tournament_core_pkg.sv
// Shared widths, LFSR constants, fitness coefficients and the LFSR stepping helper.
// Latency: n/a (declarations and a pure combinational function).
// Backpressure: n/a.
package ga_pkg;

    localparam int CHROM_W    = 8;
    localparam int FIT_W      = 27;
    localparam int LFSR_W     = 32;
    localparam int LFSR_STEPS = 16;

    localparam logic [LFSR_W-1:0] LFSR_MASK     = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 32'h0000_0001;

    typedef logic signed [CHROM_W-1:0] chrom_t;
    typedef logic signed [FIT_W-1:0]   fit_t;

    // Cubic coefficients held at full fitness width so the evaluator stays single-width.
    localparam fit_t C2 = fit_t'(-15);
    localparam fit_t C0 = fit_t'(500);

    // Sixteen Galois steps of x^32+x^22+x^2+x+1, unrolled so one clock yields two fresh bytes.
    function automatic logic [LFSR_W-1:0] lfsr_step16(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] r;
        r = s;
        for (int i = 0; i < LFSR_STEPS; i++) begin
            r = (r >> 1) ^ ({LFSR_W{r[0]}} & LFSR_MASK);
        end
        return r;
    endfunction

endpackage

// File: rtl/ga_tournament_core_if.sv
// Bundle of seed input and tournament pipeline outputs for the GA front end.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must accept one result per cycle.
interface ga_tournament_core_if;
    import ga_pkg::*;

    logic [LFSR_W-1:0] seed;
    chrom_t            chrom1;
    chrom_t            chrom2;
    fit_t              fitness1;
    fit_t              fitness2;
    logic              selected;
    chrom_t            winner;
    logic              out_valid;

    // Core side: takes the seed, produces chromosomes and tournament results.
    modport master (
        input  seed,
        output chrom1, chrom2, fitness1, fitness2, selected, winner, out_valid
    );

    // Environment side: supplies the seed, consumes results.
    modport slave (
        output seed,
        input  chrom1, chrom2, fitness1, fitness2, selected, winner, out_valid
    );

endinterface

// File: rtl/ga_tournament_core_fitness_eval.sv
// Fitness polynomial f(x) = x^3 - 15x^2 + 500 on one signed chromosome.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module ga_fitness_eval
    import ga_pkg::*;
(
    input  chrom_t chrom,
    output fit_t   fitness
);

    fit_t x;
    fit_t x2;
    fit_t x3;

    // All terms fit in 27 bits over the full 8-bit input range, so truncation never loses value.
    always_comb begin
        x       = fit_t'(chrom);
        x2      = x * x;
        x3      = x2 * x;
        fitness = x3 + (C2 * x2) + C0;
    end

endmodule

// File: rtl/ga_tournament_core.sv
// Two-candidate tournament: LFSR chromosomes -> registered fitness -> registered winner.
// Latency: chromosome to fitness 1 cycle, chromosome to selected/winner 2 cycles.
// Backpressure: none; fully pipelined, one tournament per cycle, never stalls.
module ga_tournament_core
    import ga_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    ga_tournament_core_if.master io
);

    logic [LFSR_W-1:0] state;
    chrom_t            chrom1;
    chrom_t            chrom2;
    fit_t              fit1_nxt;
    fit_t              fit2_nxt;
    fit_t              fitness1;
    fit_t              fitness2;
    chrom_t            chrom1_d1;
    chrom_t            chrom2_d1;
    logic              selected;
    logic              selected_next;
    chrom_t            winner;
    logic [1:0]        vld_sr;

    // Low two bytes of the LFSR are the candidates, read as two's complement.
    assign chrom1 = chrom_t'(state[7:0]);
    assign chrom2 = chrom_t'(state[15:8]);

    ga_fitness_eval u_fit1 (
        .chrom   (chrom1),
        .fitness (fit1_nxt)
    );

    ga_fitness_eval u_fit2 (
        .chrom   (chrom2),
        .fitness (fit2_nxt)
    );

    // Ties go to candidate 1.
    assign selected_next = (fitness1 >= fitness2);

    // LFSR: load seed on reset (zero seed substituted so it cannot lock up), else advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= (io.seed == '0) ? SEED_ZERO_SUB : io.seed;
        end else begin
            state <= lfsr_step16(state);
        end
    end

    // Stage 1: fitness plus the chromosomes it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            fitness1  <= '0;
            fitness2  <= '0;
            chrom1_d1 <= '0;
            chrom2_d1 <= '0;
        end else begin
            fitness1  <= fit1_nxt;
            fitness2  <= fit2_nxt;
            chrom1_d1 <= chrom1;
            chrom2_d1 <= chrom2;
        end
    end

    // Stage 2: tournament decision and winning chromosome; valid marks two post-reset edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            selected <= 1'b0;
            winner   <= '0;
            vld_sr   <= 2'b00;
        end else begin
            selected <= selected_next;
            winner   <= selected_next ? chrom1_d1 : chrom2_d1;
            vld_sr   <= {vld_sr[0], 1'b1};
        end
    end

    assign io.chrom1    = chrom1;
    assign io.chrom2    = chrom2;
    assign io.fitness1  = fitness1;
    assign io.fitness2  = fitness2;
    assign io.selected  = selected;
    assign io.winner    = winner;
    assign io.out_valid = vld_sr[1];

endmodule

// File: tb/tb_ga_tournament_core.sv
// Scoreboard bench for ga_tournament_core: directed seeds plus a modelled run with mid-run reset.
// Latency: results expected two edges after each chromosome pair.
// Backpressure: none; monitor pops one entry per valid cycle.
module tb_ga_tournament_core;

    typedef struct {
        logic              sel;
        logic signed [7:0] win;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    ga_tournament_core_if bus ();

    ga_tournament_core dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Independent reference: one Galois step at a time, 16 per cycle.
    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 16; i++) begin
            if (r[0]) r = (r >> 1) ^ 32'h8020_0003;
            else      r = r >> 1;
        end
        return r;
    endfunction

    function automatic int m_fit(input int x);
        return x * x * x - 15 * x * x + 500;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One reset edge with the given seed; checks the cleared pipeline.
    task automatic apply_reset(input logic [31:0] s, input bit expect_empty);
        reset    = 1'b1;
        bus.seed = s;
        step();
        reset    = 1'b0;
        bus.seed = ~s;
        if (expect_empty) chk("sb_drained", sb.size(), 0);
        sb.delete();
        chk("rst_fitness1", bus.fitness1, 0);
        chk("rst_fitness2", bus.fitness2, 0);
        chk("rst_selected", bus.selected, 0);
        chk("rst_winner",   bus.winner, 0);
        chk("rst_valid",    bus.out_valid, 0);
    endtask

    task automatic directed(input logic [31:0] s, input int c1, input int c2,
                            input int f1, input int f2, input logic sel, input int win);
        exp_t e;
        apply_reset(s, 1'b1);
        chk("dir_chrom1", bus.chrom1, c1);
        chk("dir_chrom2", bus.chrom2, c2);
        e.sel = sel;
        e.win = 8'(win);
        sb.push_back(e);
        step();
        chk("dir_fitness1", bus.fitness1, f1);
        chk("dir_fitness2", bus.fitness2, f2);
        chk("dir_valid_e1", bus.out_valid, 0);
        step();
        chk("dir_valid_e2", bus.out_valid, 1);
    endtask

    task automatic model_run(input logic [31:0] s, input int n, input bit expect_empty, input bit drain);
        logic [31:0] st;
        int          c1;
        int          c2;
        exp_t        e;
        apply_reset(s, expect_empty);
        st = (s == 32'd0) ? 32'd1 : s;
        for (int k = 0; k < n; k++) begin
            c1 = int'($signed(st[7:0]));
            c2 = int'($signed(st[15:8]));
            chk("run_chrom1", bus.chrom1, c1);
            chk("run_chrom2", bus.chrom2, c2);
            e.sel = (m_fit(c1) >= m_fit(c2));
            e.win = e.sel ? 8'(c1) : 8'(c2);
            sb.push_back(e);
            bus.seed = $urandom;
            step();
            st = m_step(st);
            chk("run_fitness1", bus.fitness1, m_fit(c1));
            chk("run_fitness2", bus.fitness2, m_fit(c2));
            chk("run_valid", bus.out_valid, (k >= 1) ? 1 : 0);
        end
        if (drain) step();
    endtask

    // Monitor: every valid result must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got valid result sel=%0d win=%0d, expected none",
                             bus.selected, bus.winner);
                end else begin
                    e = sb.pop_front();
                    chk("mon_selected", bus.selected, e.sel);
                    chk("mon_winner",   bus.winner, e.win);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.seed = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        directed(32'hA1EF_CDE5, -27, -51, -30118, -171166, 1'b1, -27);
        directed(32'h0000_0000,   1,   0,    486,     500, 1'b0,   0);
        directed(32'h0000_0F0F,  15,  15,    500,     500, 1'b1,  15);
        directed(32'h0000_7F80, -128, 127, -2342412, 1806948, 1'b0, 127);

        model_run(32'h1234_5678, 150, 1'b1, 1'b0);
        model_run(32'hDEAD_BEEF, 150, 1'b0, 1'b1);
        apply_reset(32'h0000_0001, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
